// File: rtl/otter_csr_pkg.sv
// Shared CSR definitions for the OTTER interrupt/CSR slice: addresses, op codes,
// mstatus bit positions and the read-modify-write helper.
package otter_csr_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MIE       = 12'h304,
    CSR_MTVEC     = 12'h305,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MIP       = 12'h344,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82,
    CSR_CYCLE     = 12'hC00,
    CSR_INSTRET   = 12'hC02,
    CSR_CYCLEH    = 12'hC80,
    CSR_INSTRETH  = 12'hC82
  } csr_addr_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_e;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old,
                                            input logic [31:0] wd);
    case (op)
      OP_WRITE: return wd;
      OP_SET:   return old | wd;
      OP_CLEAR: return old & ~wd;
      default:  return old;
    endcase
  endfunction

endpackage

// File: rtl/otter_csr_irq_if.sv
// CSR access bus: address, operation and write data in, combinational read data out.
interface otter_csr_irq_if;
  logic [11:0] addr;
  logic [1:0]  op;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output addr, output op, output wd, input rd);
  modport slave  (input addr, input op, input wd, output rd);
endinterface

// File: rtl/otter_csr_counter.sv
// Free-running CSR counter with independent 32-bit half loads; a load beats the increment.
module otter_csr_counter #(
  parameter int unsigned CNT_W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_lo,
  input  logic        load_hi,
  input  logic        inc,
  input  logic [31:0] wd,
  output logic [31:0] lo,
  output logic [31:0] hi
);

  if (CNT_W == 64) begin : g_64
    logic [63:0] cnt, cnt_nxt;

    always_comb begin
      cnt_nxt = cnt;
      if (load_lo)      cnt_nxt = {cnt[63:32], wd};
      else if (load_hi) cnt_nxt = {wd, cnt[31:0]};
      else if (inc)     cnt_nxt = cnt + 64'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt_nxt;
    end

    assign lo = cnt[31:0];
    assign hi = cnt[63:32];
  end else begin : g_32
    logic [31:0] cnt;
    logic        unused_load_hi;

    // No high half exists, so high-half loads are dropped and it reads as zero.
    assign unused_load_hi = load_hi;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)          cnt <= '0;
      else if (load_lo) cnt <= wd;
      else if (inc)     cnt <= cnt + 32'd1;
    end

    assign lo = cnt;
    assign hi = '0;
  end

endmodule

// File: rtl/otter_csr_irq.sv
// Machine-mode CSR file with level-sensitive interrupt lines, trap entry/return
// handling and cycle/instret counters.
module otter_csr_irq
  import otter_csr_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned CNT_W   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  otter_csr_irq_if.slave     csr,
  input  logic [31:0]        next_pc,
  input  logic               int_taken,
  input  logic               int_ret,
  input  logic               instr_retired,
  output logic [31:0]        mepc,
  output logic [31:0]        mtvec,
  output logic               int_req
);

  logic               mie_bit, mpie_bit;
  logic [NUM_IRQ-1:0] mie_q, mip_q, pend;
  logic [31:2]        mtvec_q, mepc_q;
  logic [31:0]        mcause_q;
  logic [31:0]        rd_v, new_val, cause;
  logic [31:0]        cyc_lo, cyc_hi, ins_lo, ins_hi;
  logic [3:0]         irq_k;
  logic               wr_en, found;
  logic               unused_pc;
  csr_op_e            op;

  assign unused_pc = ^next_pc[1:0];
  assign op        = csr_op_e'(csr.op);
  assign wr_en     = (op != OP_NONE);
  assign pend      = mip_q & mie_q;
  assign int_req   = mie_bit & (|pend);
  assign mepc      = {mepc_q, 2'b00};
  assign mtvec     = {mtvec_q, 2'b00};

  always_comb begin
    rd_v = '0;
    case (csr.addr)
      CSR_MSTATUS: begin
        rd_v[MSTATUS_MIE]  = mie_bit;
        rd_v[MSTATUS_MPIE] = mpie_bit;
      end
      CSR_MIE:                   rd_v[16 +: NUM_IRQ] = mie_q;
      CSR_MIP:                   rd_v[16 +: NUM_IRQ] = mip_q;
      CSR_MTVEC:                 rd_v = mtvec;
      CSR_MEPC:                  rd_v = mepc;
      CSR_MCAUSE:                rd_v = mcause_q;
      CSR_MCYCLE,   CSR_CYCLE:   rd_v = cyc_lo;
      CSR_MCYCLEH,  CSR_CYCLEH:  rd_v = cyc_hi;
      CSR_MINSTRET, CSR_INSTRET: rd_v = ins_lo;
      CSR_MINSTRETH, CSR_INSTRETH: rd_v = ins_hi;
      default:                   rd_v = '0;
    endcase
  end

  assign csr.rd  = rd_v;
  assign new_val = csr_apply(op, rd_v, csr.wd);

  // Lowest-index pending-and-enabled line; defaults to line 0 when none qualifies.
  always_comb begin
    irq_k = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (pend[i] && !found) begin
        found = 1'b1;
        irq_k = i[3:0];
      end
    end
    cause = {1'b1, 26'd0, 1'b1, irq_k};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_bit  <= 1'b0;
      mpie_bit <= 1'b0;
      mie_q    <= '0;
      mip_q    <= '0;
      mtvec_q  <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      mip_q <= irq_in;
      if (wr_en && csr.addr == CSR_MIE)   mie_q   <= new_val[16 +: NUM_IRQ];
      if (wr_en && csr.addr == CSR_MTVEC) mtvec_q <= new_val[31:2];
      // Trap entry owns mepc/mcause/mstatus this cycle; otherwise mret overrides an mstatus write.
      if (int_taken) begin
        mepc_q   <= next_pc[31:2];
        mpie_bit <= mie_bit;
        mie_bit  <= 1'b0;
        mcause_q <= cause;
      end else begin
        if (wr_en) begin
          case (csr.addr)
            CSR_MSTATUS: begin
              mie_bit  <= new_val[MSTATUS_MIE];
              mpie_bit <= new_val[MSTATUS_MPIE];
            end
            CSR_MEPC:   mepc_q   <= new_val[31:2];
            CSR_MCAUSE: mcause_q <= new_val;
            default: ;
          endcase
        end
        if (int_ret) begin
          mie_bit  <= mpie_bit;
          mpie_bit <= 1'b1;
        end
      end
    end
  end

  otter_csr_counter #(.CNT_W(CNT_W)) u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .load_lo (wr_en && csr.addr == CSR_MCYCLE),
    .load_hi (wr_en && csr.addr == CSR_MCYCLEH),
    .inc     (1'b1),
    .wd      (new_val),
    .lo      (cyc_lo),
    .hi      (cyc_hi)
  );

  otter_csr_counter #(.CNT_W(CNT_W)) u_minstret (
    .clk     (clk),
    .rst     (rst),
    .load_lo (wr_en && csr.addr == CSR_MINSTRET),
    .load_hi (wr_en && csr.addr == CSR_MINSTRETH),
    .inc     (instr_retired),
    .wd      (new_val),
    .lo      (ins_lo),
    .hi      (ins_hi)
  );

endmodule

// File: tb/tb_otter_csr_irq.sv
// Directed self-checking bench for otter_csr_irq (64-bit counters plus a 32-bit counter instance).
module tb_otter_csr_irq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  irq_in = '0;
  logic [31:0] next_pc = '0;
  logic        int_taken = 1'b0;
  logic        int_ret = 1'b0;
  logic        instr_retired = 1'b0;
  logic [31:0] mepc, mtvec, mepc32, mtvec32;
  logic        int_req, int_req32;
  int          n_checks = 0;
  int          n_pass = 0;

  otter_csr_irq_if bus ();
  otter_csr_irq_if bus32 ();

  assign bus32.addr = bus.addr;
  assign bus32.op   = bus.op;
  assign bus32.wd   = bus.wd;

  otter_csr_irq #(.NUM_IRQ(4), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .csr(bus.slave), .next_pc(next_pc),
    .int_taken(int_taken), .int_ret(int_ret), .instr_retired(instr_retired),
    .mepc(mepc), .mtvec(mtvec), .int_req(int_req)
  );

  otter_csr_irq #(.NUM_IRQ(4), .CNT_W(32)) dut32 (
    .clk(clk), .rst(rst), .irq_in(irq_in), .csr(bus32.slave), .next_pc(next_pc),
    .int_taken(int_taken), .int_ret(int_ret), .instr_retired(instr_retired),
    .mepc(mepc32), .mtvec(mtvec32), .int_req(int_req32)
  );

  initial forever #5 clk = ~clk;

  task automatic csr_op(input logic [11:0] a, input logic [1:0] o, input logic [31:0] d);
    bus.addr = a;
    bus.op   = o;
    bus.wd   = d;
    @(posedge clk); #1;
    bus.op   = 2'b00;
    #1;
  endtask

  task automatic rd_at(input logic [11:0] a);
    bus.addr = a;
    #1;
  endtask

  task automatic test_reset;
    bus.addr = 12'h300; bus.op = 2'b00; bus.wd = '0;
    #1 rst = 1'b1;
    #2;
    n_checks++; if (bus.rd !== 32'h0) $display("FAIL reset_mstatus got %h exp %h", bus.rd, 32'h0); else n_pass++;
    n_checks++; if (int_req !== 1'b0) $display("FAIL reset_int_req got %b exp 0", int_req); else n_pass++;
    n_checks++; if (mtvec !== 32'h0) $display("FAIL reset_mtvec got %h exp %h", mtvec, 32'h0); else n_pass++;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_irq_enable;
    csr_op(12'h300, 2'b01, 32'h0000_0088);
    n_checks++; if (bus.rd !== 32'h88) $display("FAIL mstatus_write got %h exp %h", bus.rd, 32'h88); else n_pass++;
    csr_op(12'h304, 2'b10, 32'h0002_0000);
    n_checks++; if (bus.rd !== 32'h0002_0000) $display("FAIL mie_set got %h exp %h", bus.rd, 32'h0002_0000); else n_pass++;
    irq_in = 4'b0010;
    #1;
    n_checks++; if (int_req !== 1'b0) $display("FAIL int_req_early got %b exp 0", int_req); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (int_req !== 1'b1) $display("FAIL int_req_rise got %b exp 1", int_req); else n_pass++;
    rd_at(12'h344);
    n_checks++; if (bus.rd !== 32'h0002_0000) $display("FAIL mip_read got %h exp %h", bus.rd, 32'h0002_0000); else n_pass++;
  endtask

  task automatic test_trap;
    csr_op(12'h304, 2'b01, 32'h0006_0000);
    irq_in = 4'b0110;
    @(posedge clk); #1;
    int_taken = 1'b1; next_pc = 32'h100;
    @(posedge clk); #1;
    int_taken = 1'b0;
    rd_at(12'h342);
    n_checks++; if (bus.rd !== 32'h8000_0011) $display("FAIL trap_mcause got %h exp %h", bus.rd, 32'h8000_0011); else n_pass++;
    n_checks++; if (mepc !== 32'h100) $display("FAIL trap_mepc got %h exp %h", mepc, 32'h100); else n_pass++;
    rd_at(12'h300);
    n_checks++; if (bus.rd !== 32'h80) $display("FAIL trap_mstatus got %h exp %h", bus.rd, 32'h80); else n_pass++;
    n_checks++; if (int_req !== 1'b0) $display("FAIL trap_int_req got %b exp 0", int_req); else n_pass++;
    int_ret = 1'b1;
    @(posedge clk); #1;
    int_ret = 1'b0;
    #1;
    n_checks++; if (bus.rd !== 32'h88) $display("FAIL mret_mstatus got %h exp %h", bus.rd, 32'h88); else n_pass++;
    n_checks++; if (int_req !== 1'b1) $display("FAIL mret_int_req got %b exp 1", int_req); else n_pass++;
  endtask

  task automatic test_set_clear;
    irq_in = 4'b0000;
    csr_op(12'h300, 2'b01, 32'h80);
    bus.op = 2'b10; bus.wd = 32'h8;
    #1;
    n_checks++; if (bus.rd !== 32'h80) $display("FAIL set_old_rd got %h exp %h", bus.rd, 32'h80); else n_pass++;
    @(posedge clk); #1;
    bus.op = 2'b00;
    #1;
    n_checks++; if (bus.rd !== 32'h88) $display("FAIL set_new got %h exp %h", bus.rd, 32'h88); else n_pass++;
    bus.op = 2'b11; bus.wd = 32'h80;
    #1;
    n_checks++; if (bus.rd !== 32'h88) $display("FAIL clr_old_rd got %h exp %h", bus.rd, 32'h88); else n_pass++;
    @(posedge clk); #1;
    bus.op = 2'b00;
    #1;
    n_checks++; if (bus.rd !== 32'h08) $display("FAIL clr_new got %h exp %h", bus.rd, 32'h08); else n_pass++;
  endtask

  task automatic test_regs;
    csr_op(12'h305, 2'b01, 32'h0000_1235);
    n_checks++; if (mtvec !== 32'h1234) $display("FAIL mtvec_mask got %h exp %h", mtvec, 32'h1234); else n_pass++;
    n_checks++; if (bus.rd !== 32'h1234) $display("FAIL mtvec_rd got %h exp %h", bus.rd, 32'h1234); else n_pass++;
    csr_op(12'h341, 2'b01, 32'hABCD_0003);
    n_checks++; if (mepc !== 32'hABCD_0000) $display("FAIL mepc_mask got %h exp %h", mepc, 32'hABCD_0000); else n_pass++;
    csr_op(12'h342, 2'b01, 32'h0000_0005);
    n_checks++; if (bus.rd !== 32'h5) $display("FAIL mcause_rw got %h exp %h", bus.rd, 32'h5); else n_pass++;
    csr_op(12'h344, 2'b01, 32'hFFFF_FFFF);
    n_checks++; if (bus.rd !== 32'h0) $display("FAIL mip_ro got %h exp %h", bus.rd, 32'h0); else n_pass++;
    csr_op(12'h123, 2'b01, 32'hDEAD_BEEF);
    n_checks++; if (bus.rd !== 32'h0) $display("FAIL unimpl_rd got %h exp %h", bus.rd, 32'h0); else n_pass++;
  endtask

  task automatic test_trap_priority;
    irq_in = 4'b0000;
    @(posedge clk); #1;
    int_taken = 1'b1; next_pc = 32'h300;
    csr_op(12'h341, 2'b01, 32'h200);
    int_taken = 1'b0;
    n_checks++; if (mepc !== 32'h300) $display("FAIL prio_mepc got %h exp %h", mepc, 32'h300); else n_pass++;
    rd_at(12'h342);
    n_checks++; if (bus.rd !== 32'h8000_0010) $display("FAIL prio_mcause got %h exp %h", bus.rd, 32'h8000_0010); else n_pass++;
  endtask

  task automatic test_counters;
    csr_op(12'hB00, 2'b01, 32'hFFFF_FFFF);
    rd_at(12'hB00);
    n_checks++; if (bus.rd !== 32'hFFFF_FFFF) $display("FAIL mcycle_preset got %h exp %h", bus.rd, 32'hFFFF_FFFF); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.rd !== 32'h0) $display("FAIL mcycle_wrap got %h exp %h", bus.rd, 32'h0); else n_pass++;
    n_checks++; if (bus32.rd !== 32'h0) $display("FAIL mcycle32_wrap got %h exp %h", bus32.rd, 32'h0); else n_pass++;
    rd_at(12'hB80);
    n_checks++; if (bus.rd !== 32'h1) $display("FAIL mcycleh_carry got %h exp %h", bus.rd, 32'h1); else n_pass++;
    n_checks++; if (bus32.rd !== 32'h0) $display("FAIL mcycleh32_zero got %h exp %h", bus32.rd, 32'h0); else n_pass++;
    rd_at(12'hC80);
    n_checks++; if (bus.rd !== 32'h1) $display("FAIL cycleh_shadow got %h exp %h", bus.rd, 32'h1); else n_pass++;
    csr_op(12'hB80, 2'b01, 32'h5);
    n_checks++; if (bus.rd !== 32'h5) $display("FAIL mcycleh_write got %h exp %h", bus.rd, 32'h5); else n_pass++;
    n_checks++; if (bus32.rd !== 32'h0) $display("FAIL mcycleh32_ignored got %h exp %h", bus32.rd, 32'h0); else n_pass++;
    instr_retired = 1'b1;
    csr_op(12'hB02, 2'b01, 32'd100);
    n_checks++; if (bus.rd !== 32'd100) $display("FAIL minstret_write_wins got %0d exp %0d", bus.rd, 100); else n_pass++;
    repeat (3) @(posedge clk);
    #1 instr_retired = 1'b0;
    rd_at(12'hC02);
    n_checks++; if (bus.rd !== 32'd103) $display("FAIL instret_count got %0d exp %0d", bus.rd, 103); else n_pass++;
    csr_op(12'hC02, 2'b01, 32'h0);
    rd_at(12'hB02);
    n_checks++; if (bus.rd !== 32'd103) $display("FAIL instret_shadow_ro got %0d exp %0d", bus.rd, 103); else n_pass++;
  endtask

  task automatic test_async_reset;
    csr_op(12'h300, 2'b01, 32'h8);
    csr_op(12'h304, 2'b01, 32'h0001_0000);
    irq_in = 4'b0001;
    @(posedge clk); #1;
    n_checks++; if (int_req !== 1'b1) $display("FAIL pre_reset_int_req got %b exp 1", int_req); else n_pass++;
    bus.addr = 12'h300;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_checks++; if (int_req !== 1'b0) $display("FAIL async_int_req got %b exp 0", int_req); else n_pass++;
    n_checks++; if (mtvec !== 32'h0) $display("FAIL async_mtvec got %h exp %h", mtvec, 32'h0); else n_pass++;
    n_checks++; if (mepc !== 32'h0) $display("FAIL async_mepc got %h exp %h", mepc, 32'h0); else n_pass++;
    n_checks++; if (bus.rd !== 32'h0) $display("FAIL async_mstatus got %h exp %h", bus.rd, 32'h0); else n_pass++;
    rd_at(12'h304);
    n_checks++; if (bus.rd !== 32'h0) $display("FAIL async_mie got %h exp %h", bus.rd, 32'h0); else n_pass++;
    rd_at(12'hB00);
    n_checks++; if (bus.rd !== 32'h0) $display("FAIL async_mcycle got %h exp %h", bus.rd, 32'h0); else n_pass++;
    @(negedge clk) rst = 1'b0;
    irq_in = 4'b0000;
  endtask

  initial begin
    test_reset;
    test_irq_enable;
    test_trap;
    test_set_clear;
    test_regs;
    test_trap_priority;
    test_counters;
    test_async_reset;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/otter_csr_irq.md
OTTER_CSR_IRQ -- requirements
Module: otter_csr_irq

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of external interrupt lines, legal range 1..16.
REQ-002 SHALL have parameter CNT_W, default 64, width of the cycle and instret counters, legal values 32 or 64.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port irq_in, input, NUM_IRQ, level-sensitive interrupt requests.
REQ-006 SHALL have port addr, input, 12, CSR address.
REQ-007 SHALL have port op, input, 2, CSR operation: 00 none, 01 write, 10 set-bits, 11 clear-bits.
REQ-008 SHALL have port wd, input, 32, CSR write data or bit mask.
REQ-009 SHALL have port next_pc, input, 32, return address captured on trap entry.
REQ-010 SHALL have port int_taken, input, 1, trap entry strobe.
REQ-011 SHALL have port int_ret, input, 1, mret strobe.
REQ-012 SHALL have port instr_retired, input, 1, one instruction retired this cycle.
REQ-013 SHALL have port rd, output, 32, CSR read data.
REQ-014 SHALL have ports mepc and mtvec, output, 32 each, trap return address and handler base.
REQ-015 SHALL have port int_req, output, 1, interrupt pending and enabled.

Function
REQ-016 SHALL implement mstatus (0x300) with MIE at bit 3 and MPIE at bit 7; all other bits read 0.
REQ-017 SHALL implement mie (0x304) and mip (0x344), each holding NUM_IRQ bits at [16+k]; mip is read-only; other bits read 0.
REQ-018 SHALL implement mtvec (0x305) and mepc (0x341), with bits [1:0] forced to 0.
REQ-019 SHALL implement mcause (0x342) as a read/write register.
REQ-020 SHALL implement mcycle/mcycleh (0xB00/0xB80), minstret/minstreth (0xB02/0xB82), and read-only shadows at 0xC00/0xC80/0xC02/0xC82.
REQ-021 SHALL, when CNT_W=32, read the high halves as 0 and ignore writes to them.
REQ-022 SHALL drive rd combinationally with the pre-update value of addr; unimplemented addresses read 0.
REQ-023 SHALL apply the new value wd, old|wd or old&~wd for op 01/10/11 at the next edge; writes to read-only or unimplemented addresses are ignored.
REQ-024 SHALL register irq_in into mip every cycle, so int_req rises one cycle after irq_in rises.
REQ-025 SHALL compute int_req = MIE & |(mip & mie).
REQ-026 SHALL on int_taken set mepc<=next_pc, MPIE<=MIE, MIE<=0, mcause<=0x8000_0000|(16+k), where k is the lowest-index pending-and-enabled line; if no line qualifies, k=0.
REQ-027 SHALL on int_ret set MIE<=MPIE and MPIE<=1.
REQ-028 SHALL give int_taken priority over int_ret and over a same-cycle CSR write to mepc, mcause or mstatus.
REQ-029 SHALL increment mcycle every cycle and minstret when instr_retired=1, wrapping modulo 2^CNT_W.
REQ-030 SHALL let a CSR write to a counter half take precedence over that cycle's increment; the other half is unchanged.

Reset
REQ-031 SHALL on rst clear mstatus, mie, mip, mtvec, mepc, mcause and both counters to 0 immediately, independent of clk.
REQ-032 SHALL hold rd at 0 for implemented registers and int_req at 0 while rst is high; a trap or write in progress is discarded.

Structure
REQ-033 SHALL take the CSR address enum, the op encoding and the mstatus bit positions from shared package otter_csr_pkg.
REQ-034 SHALL instantiate sub-module otter_csr_counter, parametrised by CNT_W with load-low/load-high/increment, twice.

Verification
REQ-035 SHALL cover: write 0x0000_0088 to mstatus, then set mie bit 17 and raise irq_in[1] -> int_req=1 one cycle later.
REQ-036 SHALL cover: irq_in=4'b0110 with both enabled, int_taken with next_pc=0x100 -> mcause=0x8000_0011, mepc=0x100, MIE=0, MPIE=1; then int_ret -> MIE=1.
REQ-037 SHALL cover: op=10 with wd=0x8 on mstatus=0x80 -> 0x88; then op=11 with wd=0x80 -> 0x08; rd shows the old value during each op cycle.
REQ-038 SHALL cover: mcycle preset to 0xFFFF_FFFF -> next cycle mcycle=0, mcycleh=1; with CNT_W=32, mcycleh reads 0.
REQ-039 SHALL cover: int_taken and a CSR write of mepc=0x200 in the same cycle with next_pc=0x300 -> mepc=0x300.
REQ-040 SHALL cover: rst asserted mid-cycle between edges -> all registers 0 and int_req=0 without waiting for a clock edge.
